// File: rtl/set_cond_sequencer_pkg.sv
// Shared encodings for the set-condition sequencer: condition opcodes and FSM states.
package set_cond_sequencer_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SET_OP_SLT = 3'd0,
        SET_OP_SEQ = 3'd1,
        SET_OP_SNE = 3'd2,
        SET_OP_SGT = 3'd3,
        SET_OP_SLE = 3'd4,
        SET_OP_SGE = 3'd5
    } set_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/set_cond_sequencer_if.sv
// Request, subtractor and response channels of the set-condition sequencer.
interface set_cond_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             sub_valid;
    logic             sub_ready;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic             diff_valid;
    logic [WIDTH-1:0] diff;
    logic             diff_zf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

    // master: the sequencer itself; slave: issue logic, subtractor and consumer
    modport master (
        input  req_valid, req_op, req_a, req_b, sub_ready, diff_valid, diff, diff_zf, rsp_ready,
        output req_ready, sub_valid, sub_a, sub_b, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, sub_ready, diff_valid, diff, diff_zf, rsp_ready,
        input  req_ready, sub_valid, sub_a, sub_b, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/set_cond_sequencer_eval.sv
// Combinational condition evaluator: (op, difference sign, zero flag) -> cond, reserved-op flag.
module set_cond_eval
    import set_cond_sequencer_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic            msb,
    input  logic            zf,
    output logic            cond,
    output logic            reserved
);

    // Sign bit only: no overflow correction is applied to the difference.
    always_comb begin
        cond     = 1'b0;
        reserved = 1'b0;
        case (op)
            SET_OP_SLT: cond = msb;
            SET_OP_SEQ: cond = zf;
            SET_OP_SNE: cond = ~zf;
            SET_OP_SGT: cond = ~zf & ~msb;
            SET_OP_SLE: cond = zf | msb;
            SET_OP_SGE: cond = ~msb;
            default:    reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/set_cond_sequencer.sv
// Multi-cycle set-condition controller: issues a-b to the shared subtractor, waits for the
// difference (with timeout) and returns a zero-extended condition result.
module set_cond_sequencer
    import set_cond_sequencer_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    set_cond_sequencer_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             sub_valid_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [TW-1:0]    timer;

    logic [OP_W-1:0]  op_sel;
    logic             cond;
    logic             reserved;

    // One evaluator serves both the accept-time reserved check and the WAIT-time condition.
    assign op_sel = (state == ST_IDLE) ? bus.req_op : op_q;

    set_cond_eval u_eval (
        .op       (op_sel),
        .msb      (bus.diff[WIDTH-1]),
        .zf       (bus.diff_zf),
        .cond     (cond),
        .reserved (reserved)
    );

    assign bus.req_ready  = (state == ST_IDLE) && !rst;
    assign bus.sub_valid  = sub_valid_q;
    assign bus.sub_a      = a_q;
    assign bus.sub_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            sub_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        a_q  <= bus.req_a;
                        b_q  <= bus.req_b;
                        if (reserved) begin
                            state       <= ST_RESP;
                            result_q    <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state       <= ST_ISSUE;
                            sub_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.sub_ready) begin
                        sub_valid_q <= 1'b0;
                        timer       <= '0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + TW'(1);
                    // A difference arriving on the timeout cycle still yields a normal result.
                    if (bus.diff_valid) begin
                        result_q    <= {{(WIDTH-1){1'b0}}, cond};
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end else if (timer == TIMER_LAST) begin
                        result_q    <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
